score_bank_loader: RTL

Transmit side of the ScoreBank sequence-load interface. Accepts an ASCII nucleotide byte stream, one sequence per burst. Packs each burst into a ScoreBank input word: {type, ID, length, 2-bit bases}. Issues each word with a one-cycle ld_sequence pulse, honouring the bank's full back-pressure for target sequences.

---
 rtl/score_bank_loader_if.sv | 32 +++
 rtl/score_bank_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/score_bank_loader_if.sv
// score_bank_loader_if: character-stream and ScoreBank load signals for the loader.
//   char_in/char_vld/char_last/is_query : ASCII sequence stream into the loader
//   char_rdy                            : loader accepts a character this cycle
//   full                                : bank sequence registers full (target back-pressure)
//   data_out/ld_sequence                : packed ScoreBank word and its one-cycle load strobe
// Modports: master = loader side, slave = character source / bank side.
interface score_bank_loader_if #(
    parameter int unsigned ID_WIDTH      = 48,
    parameter int unsigned LEN_WIDTH     = 12,
    parameter int unsigned TARGET_LENGTH = 128
);
    localparam int unsigned IN_WIDTH = 2 + ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH;

    logic [7:0]          char_in;
    logic                char_vld;
    logic                char_last;
    logic                is_query;
    logic                char_rdy;
    logic                full;
    logic [IN_WIDTH-1:0] data_out;
    logic                ld_sequence;

    modport master (
        input  char_in, char_vld, char_last, is_query, full,
        output char_rdy, data_out, ld_sequence
    );

    modport slave (
        output char_in, char_vld, char_last, is_query, full,
        input  char_rdy, data_out, ld_sequence
    );
endinterface

// File: rtl/score_bank_loader.sv
// score_bank_loader: packs an ASCII nucleotide burst into a ScoreBank word
// {type, ID, LEN, 2-bit bases} and issues it with a one-cycle ld_sequence pulse.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   bus (master)  : char stream in, char_rdy out, full in, data_out/ld_sequence out
//   err_invalid   : sticky, a non-ACGT/LF/CR char was seen      (SCORE_LOADER_ERR_EN)
//   err_overlen   : sticky, a sequence exceeded TARGET_LENGTH    (SCORE_LOADER_ERR_EN)
// Build option: define SCORE_LOADER_ERR_EN to add the sticky error outputs.
module score_bank_loader #(
    parameter int unsigned ID_WIDTH      = 48,
    parameter int unsigned LEN_WIDTH     = 12,
    parameter int unsigned TARGET_LENGTH = 128
) (
    input  logic clk,
    input  logic rst,
`ifdef SCORE_LOADER_ERR_EN
    output logic err_invalid,
    output logic err_overlen,
`endif
    score_bank_loader_if.master bus
);
    localparam int unsigned BASE_WIDTH = 2 * TARGET_LENGTH;
    localparam int unsigned IN_WIDTH   = 2 + ID_WIDTH + LEN_WIDTH + BASE_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;

    logic [1:0]            state, state_nxt;
    logic [IN_WIDTH-1:0]   data_q, data_nxt;
    logic                  ld_q, rdy_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_WIDTH-1:0]  count_q, count_base, count_nxt;
    logic                  query_q, query_cur;
    logic                  xfer, last_xfer, is_skip, is_base, room, store, empty, fire;
    logic [7:0]            lc;
    logic [1:0]            code;
    logic [BASE_WIDTH-1:0] base_cur, slot_mask, slot_val;

    // Case-insensitive nucleotide decode; anything else packs as 00
    always_comb begin
        lc   = bus.char_in | 8'h20;
        code = 2'b00;
        case (lc)
            8'h61:   code = 2'b10;
            8'h63:   code = 2'b01;
            8'h67:   code = 2'b11;
            default: code = 2'b00;
        endcase
    end

    assign xfer       = bus.char_vld & rdy_q;
    assign last_xfer  = xfer & bus.char_last;
    assign is_skip    = (bus.char_in == 8'h0A) || (bus.char_in == 8'h0D);
    assign is_base    = xfer & ~is_skip;
    // A first char in IDLE starts from an empty sequence regardless of stale registers
    assign count_base = (state == S_IDLE) ? '0 : count_q;
    assign query_cur  = (state == S_IDLE) ? bus.is_query : query_q;
    assign room       = count_base < LEN_WIDTH'(TARGET_LENGTH);
    assign store      = is_base & room;
    assign count_nxt  = store ? count_base + LEN_WIDTH'(1) : count_base;
    assign empty      = (count_nxt == '0);
    // Queries ignore back-pressure; targets wait for full=0
    assign fire       = (state == S_ISSUE) && (query_q || !bus.full);

    // Slot n sits at the MSB end of the base field, shifted down by 2n
    assign base_cur  = (state == S_IDLE) ? '0 : data_q[BASE_WIDTH-1:0];
    assign slot_mask = {2'b11, {(BASE_WIDTH-2){1'b0}}} >> {count_base, 1'b0};
    assign slot_val  = {code,  {(BASE_WIDTH-2){1'b0}}} >> {count_base, 1'b0};

    // Packet build: bases on each stored char, header when the sequence closes
    always_comb begin
        data_nxt = data_q;
        if (xfer) begin
            data_nxt[BASE_WIDTH-1:0] = store ? ((base_cur & ~slot_mask) | slot_val) : base_cur;
        end
        if (last_xfer && !empty) begin
            data_nxt[IN_WIDTH-1 -: 2]                  = query_cur ? 2'b01 : 2'b10;
            data_nxt[BASE_WIDTH+LEN_WIDTH +: ID_WIDTH] = query_cur ? '0 : id_q;
            data_nxt[BASE_WIDTH +: LEN_WIDTH]          = count_nxt;
        end
    end

    // Next-state logic; an empty sequence closes straight back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (last_xfer) begin
                    state_nxt = empty ? S_IDLE : S_ISSUE;
                end else if (xfer) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_ISSUE: begin
                if (fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            ld_q    <= 1'b0;
            rdy_q   <= 1'b1;
            id_q    <= '0;
            count_q <= '0;
            query_q <= 1'b0;
        end else begin
            data_q <= data_nxt;
            ld_q   <= fire;
            rdy_q  <= (state_nxt != S_ISSUE);
            if (xfer) begin
                count_q <= count_nxt;
            end
            if (xfer && (state == S_IDLE)) begin
                query_q <= bus.is_query;
            end
            if (fire && !query_q) begin
                id_q <= id_q + ID_WIDTH'(1);
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.ld_sequence = ld_q;
    assign bus.char_rdy    = rdy_q;

`ifdef SCORE_LOADER_ERR_EN
    logic bad_char;

    assign bad_char = !((lc == 8'h61) || (lc == 8'h63) || (lc == 8'h67) || (lc == 8'h74));

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_invalid <= 1'b0;
            err_overlen <= 1'b0;
        end else begin
            err_invalid <= err_invalid | (is_base & bad_char);
            err_overlen <= err_overlen | (is_base & ~room);
        end
    end
`endif
endmodule
